seven_segment_mux_ctrl: RTL



---
 rtl/seven_segment_mux_ctrl_if.sv | 25 ++
 rtl/seven_segment_mux_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/seven_segment_mux_ctrl_if.sv
// Application-side bundle for seven_segment_mux_ctrl: display data and load strobe in,
// board pin drives and status out.
interface seven_segment_mux_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] dataIn;
  logic [NUM_DIGITS-1:0]   digitDisplay;
  logic [NUM_DIGITS-1:0]   digitPoint;
  logic [3:0]              brightness;
  logic                    data_load;
  logic [NUM_DIGITS-1:0]   anode;
  logic [7:0]              segment;
  logic                    frame_start;
  logic                    update_pending;

  modport master (
    output dataIn, digitDisplay, digitPoint, brightness, data_load,
    input  anode, segment, frame_start, update_pending
  );

  modport slave (
    input  dataIn, digitDisplay, digitPoint, brightness, data_load,
    output anode, segment, frame_start, update_pending
  );
endinterface

// File: rtl/seven_segment_mux_ctrl.sv
// N-digit multiplexed seven-segment controller with per-slot blanking and frame-synchronous
// double-buffered data. Define SSD_BRIGHTNESS_EN to add 4-bit PWM brightness gating.
module seven_segment_mux_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic clk,
  input logic reset_n,
  seven_segment_mux_ctrl_if.slave bus
);

  localparam int CNT_W  = $clog2(SLOT_CYCLES);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DATA_W = 4 * NUM_DIGITS;

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        slot_cnt;
  logic [IDX_W-1:0]        digit_idx;
  logic                    slot_last, digit_last, boundary;
  logic [DATA_W-1:0]       act_data, pend_data;
  logic [NUM_DIGITS-1:0]   act_disp, act_dp, pend_disp, pend_dp;
  logic                    update_pending_r, frame_start_r;
  logic [NUM_DIGITS-1:0]   anode_r, drive_anode;
  logic [7:0]              segment_r;
  logic [3:0]              nibble;
  logic                    gate;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  assign slot_last  = (slot_cnt == CNT_W'(SLOT_CYCLES - 1));
  assign digit_last = (digit_idx == IDX_W'(NUM_DIGITS - 1));
  assign boundary   = (slot_cnt == '0) && (digit_idx == '0);
  assign nibble     = act_data[{digit_idx, 2'b00} +: 4];

`ifdef SSD_BRIGHTNESS_EN
  logic [3:0] pwm_cnt, act_bright;
  assign gate = (act_bright == 4'hF) || (pwm_cnt < act_bright);
`else
  logic unused_brightness;
  assign unused_brightness = ^bus.brightness;
  assign gate = 1'b1;
`endif

  always_comb begin
    drive_anode = '1;
    if (act_disp[digit_idx] && gate) drive_anode[digit_idx] = 1'b0;
  end

  // Slot sequencing and registered pin drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_BLANK;
      slot_cnt      <= '0;
      digit_idx     <= '0;
      frame_start_r <= 1'b0;
      anode_r       <= '1;
      segment_r     <= 8'hFF;
`ifdef SSD_BRIGHTNESS_EN
      pwm_cnt       <= 4'd0;
`endif
    end else begin
      frame_start_r <= boundary;
      if (slot_last) begin
        slot_cnt  <= '0;
        digit_idx <= digit_last ? '0 : digit_idx + IDX_W'(1);
        state     <= S_BLANK;
      end else begin
        slot_cnt <= slot_cnt + CNT_W'(1);
        if (slot_cnt == CNT_W'(BLANK_CYCLES - 1)) state <= S_DRIVE;
      end
`ifdef SSD_BRIGHTNESS_EN
      pwm_cnt <= (state == S_DRIVE) ? pwm_cnt + 4'd1 : 4'd0;
`endif
      if (state == S_DRIVE) begin
        anode_r   <= drive_anode;
        segment_r <= {~act_dp[digit_idx], hex_to_seg(nibble)};
      end else begin
        anode_r   <= '1;
        segment_r <= 8'hFF;
      end
    end
  end

  // A load landing on the boundary cycle bypasses pending and goes live this frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_data         <= '0;
      act_disp         <= '0;
      act_dp           <= '0;
      pend_data        <= '0;
      pend_disp        <= '0;
      pend_dp          <= '0;
      update_pending_r <= 1'b0;
`ifdef SSD_BRIGHTNESS_EN
      act_bright       <= 4'hF;
`endif
    end else if (boundary) begin
      if (bus.data_load) begin
        act_data <= bus.dataIn;
        act_disp <= bus.digitDisplay;
        act_dp   <= bus.digitPoint;
      end else if (update_pending_r) begin
        act_data <= pend_data;
        act_disp <= pend_disp;
        act_dp   <= pend_dp;
      end
      update_pending_r <= 1'b0;
`ifdef SSD_BRIGHTNESS_EN
      act_bright <= bus.brightness;
`endif
    end else if (bus.data_load) begin
      pend_data        <= bus.dataIn;
      pend_disp        <= bus.digitDisplay;
      pend_dp          <= bus.digitPoint;
      update_pending_r <= 1'b1;
    end
  end

  assign bus.anode          = anode_r;
  assign bus.segment        = segment_r;
  assign bus.frame_start    = frame_start_r;
  assign bus.update_pending = update_pending_r;

endmodule
